// File: rtl/ps2_pkg.sv
// Shared constants and FSM encoding for the PS/2 scan-code decoder.
package ps2_pkg;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_POP    = 2'd1,
    S_DECODE = 2'd2,
    S_WAIT   = 2'd3
  } ps2_state_t;

  // Prefix bytes never name a key on their own.
  function automatic logic is_prefix(input logic [7:0] b);
    return (b == BREAK_CODE) || (b == EXT_CODE);
  endfunction

endpackage

// File: rtl/scancode_to_ascii.sv
// Set-2 scan code to lowercase ASCII lookup; unmapped codes give 0x00.
module scancode_to_ascii (
  input  logic [7:0] i_code,
  output logic [7:0] o_ascii
);

  // Letter, digit, space and enter table
  always_comb begin
    o_ascii = 8'h00;
    case (i_code)
      8'h1C: o_ascii = 8'h61;  8'h32: o_ascii = 8'h62;
      8'h21: o_ascii = 8'h63;  8'h23: o_ascii = 8'h64;
      8'h24: o_ascii = 8'h65;  8'h2B: o_ascii = 8'h66;
      8'h34: o_ascii = 8'h67;  8'h33: o_ascii = 8'h68;
      8'h43: o_ascii = 8'h69;  8'h3B: o_ascii = 8'h6A;
      8'h42: o_ascii = 8'h6B;  8'h4B: o_ascii = 8'h6C;
      8'h3A: o_ascii = 8'h6D;  8'h31: o_ascii = 8'h6E;
      8'h44: o_ascii = 8'h6F;  8'h4D: o_ascii = 8'h70;
      8'h15: o_ascii = 8'h71;  8'h2D: o_ascii = 8'h72;
      8'h1B: o_ascii = 8'h73;  8'h2C: o_ascii = 8'h74;
      8'h3C: o_ascii = 8'h75;  8'h2A: o_ascii = 8'h76;
      8'h1D: o_ascii = 8'h77;  8'h22: o_ascii = 8'h78;
      8'h35: o_ascii = 8'h79;  8'h1A: o_ascii = 8'h7A;
      8'h45: o_ascii = 8'h30;  8'h16: o_ascii = 8'h31;
      8'h1E: o_ascii = 8'h32;  8'h26: o_ascii = 8'h33;
      8'h25: o_ascii = 8'h34;  8'h2E: o_ascii = 8'h35;
      8'h36: o_ascii = 8'h36;  8'h3D: o_ascii = 8'h37;
      8'h3E: o_ascii = 8'h38;  8'h46: o_ascii = 8'h39;
      8'h29: o_ascii = 8'h20;
      8'h5A: o_ascii = 8'h0D;
      default: o_ascii = 8'h00;
    endcase
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Pops scan-code bytes from the PS/2 receiver FIFO, tracks F0/E0 prefixes,
// drops typematic repeats and presents the held key to the display logic.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       kbd_data,
  input  logic             kbd_ready,
  input  logic             kbd_overflow,
  output logic             nextdata_n,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic [7:0]       key_ascii,
  output logic             key_down,
  output logic             new_key,
  output logic [CNT_W-1:0] press_cnt,
  output logic             err_sticky
);

  ps2_state_t       r_state, w_next_state;
  logic [7:0]       r_rx_byte;
  logic             r_break_pend, r_ext_pend;
  logic             r_nextdata_n;
  logic [7:0]       r_key_code, r_key_ascii;
  logic             r_key_ext, r_key_down, r_new_key, r_err_sticky;
  logic [CNT_W-1:0] r_press_cnt;

  logic             w_break_pend, w_ext_pend;
  logic [7:0]       w_key_code, w_key_ascii, w_rom_ascii;
  logic             w_key_ext, w_key_down, w_new_key, w_match;
  logic [CNT_W-1:0] w_press_cnt;

  scancode_to_ascii u_rom (
    .i_code  (r_rx_byte),
    .o_ascii (w_rom_ascii)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: one byte per IDLE-POP-DECODE-WAIT pass
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (kbd_ready) begin
          w_next_state = S_POP;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_POP:    w_next_state = S_DECODE;
      S_DECODE: w_next_state = S_WAIT;
      S_WAIT:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  assign w_match = r_key_down && (r_rx_byte == r_key_code) && (r_ext_pend == r_key_ext);

  // Decode rules, first match wins: E0, F0, break, repeat, fresh make
  always_comb begin
    w_break_pend = r_break_pend;
    w_ext_pend   = r_ext_pend;
    w_key_code   = r_key_code;
    w_key_ext    = r_key_ext;
    w_key_ascii  = r_key_ascii;
    w_key_down   = r_key_down;
    w_new_key    = 1'b0;
    w_press_cnt  = r_press_cnt;
    if (r_state == S_DECODE) begin
      if (r_rx_byte == EXT_CODE) begin
        w_ext_pend = 1'b1;
      end else if (r_rx_byte == BREAK_CODE) begin
        w_break_pend = 1'b1;
      end else if (r_break_pend) begin
        if (w_match) begin
          w_key_down = 1'b0;
        end else begin
          w_key_down = r_key_down;
        end
        w_break_pend = 1'b0;
        w_ext_pend   = 1'b0;
      end else if (w_match || is_prefix(r_rx_byte)) begin
        w_ext_pend = 1'b0;
      end else begin
        w_key_code  = r_rx_byte;
        w_key_ext   = r_ext_pend;
        w_key_ascii = r_ext_pend ? 8'h00 : w_rom_ascii;
        w_key_down  = 1'b1;
        w_new_key   = 1'b1;
        w_press_cnt = r_press_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        w_ext_pend  = 1'b0;
      end
    end else begin
      w_new_key = 1'b0;
    end
  end

  // Pop strobe, byte capture and decoded key registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nextdata_n <= 1'b1;
      r_rx_byte    <= 8'h00;
      r_break_pend <= 1'b0;
      r_ext_pend   <= 1'b0;
      r_key_code   <= 8'h00;
      r_key_ext    <= 1'b0;
      r_key_ascii  <= 8'h00;
      r_key_down   <= 1'b0;
      r_new_key    <= 1'b0;
      r_press_cnt  <= '0;
      r_err_sticky <= 1'b0;
    end else begin
      r_nextdata_n <= (w_next_state != S_POP);
      if (r_state == S_POP) begin
        r_rx_byte <= kbd_data;
      end
      r_break_pend <= w_break_pend;
      r_ext_pend   <= w_ext_pend;
      r_key_code   <= w_key_code;
      r_key_ext    <= w_key_ext;
      r_key_ascii  <= w_key_ascii;
      r_key_down   <= w_key_down;
      r_new_key    <= w_new_key;
      r_press_cnt  <= w_press_cnt;
      r_err_sticky <= r_err_sticky | kbd_overflow;
    end
  end

  assign nextdata_n = r_nextdata_n;
  assign key_code   = r_key_code;
  assign key_ext    = r_key_ext;
  assign key_ascii  = r_key_ascii;
  assign key_down   = r_key_down;
  assign new_key    = r_new_key;
  assign press_cnt  = r_press_cnt;
  assign err_sticky = r_err_sticky;

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
Consumes scan-code bytes from the ps2_keyboard receiver FIFO through its ready/nextdata_n handshake. Tracks make, break (F0) and extended (E0) prefixes, and suppresses typematic repeats. Presents the currently held key (scan code plus ASCII), a press counter and a one-cycle new-press strobe to the seven-segment display logic in top.

Parameters:
CNT_W, 8, width of the key-press counter
Decoding constants BREAK_CODE and EXT_CODE live in the shared package (see Decomposition), not as parameters.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
kbd_data  input  8  byte at FIFO head from ps2_keyboard
kbd_ready  input  1  FIFO non-empty
kbd_overflow  input  1  FIFO overflow flag from ps2_keyboard
nextdata_n  output  1  active-low pop strobe to ps2_keyboard, registered
key_code  output  8  scan code of last pressed key
key_ext  output  1  last pressed key was E0-prefixed
key_ascii  output  8  lowercase ASCII of key_code; 0x00 if unmapped or key_ext=1
key_down  output  1  a key is currently held
new_key  output  1  one-cycle pulse on each fresh press
press_cnt  output  CNT_W  number of fresh presses, wraps
err_sticky  output  1  latched kbd_overflow, cleared only by reset

Behaviour:
- Reset (async, rst_n=0): all outputs 0 except nextdata_n=1. State S_IDLE. rx_byte, break_pend and ext_pend cleared. Reset mid-pop abandons the byte; the FIFO keeps it, since no pop completed.
- FSM, one byte per pass, 4 cycles minimum per byte:
  - S_IDLE: if kbd_ready=1, go to S_POP.
  - S_POP: nextdata_n=0 for exactly this cycle; rx_byte<=kbd_data; go to S_DECODE.
  - S_DECODE: apply the decode rules below; go to S_WAIT.
  - S_WAIT: nextdata_n=1 and one idle cycle so kbd_ready reflects the pointer update; go to S_IDLE.
- nextdata_n is low only in S_POP; it is never low two consecutive cycles.
- Decode rules in S_DECODE, first match wins:
  1. rx_byte==EXT_CODE (0xE0): ext_pend<=1.
  2. rx_byte==BREAK_CODE (0xF0): break_pend<=1.
  3. break_pend=1:
     - if key_down && rx_byte==key_code && ext_pend==key_ext, then key_down<=0; key_code, key_ext and key_ascii hold their values;
     - otherwise ignore (break of a non-held key);
     - clear both pend flags.
  4. Make with key_down && rx_byte==key_code && ext_pend==key_ext: typematic repeat. No output change; clear ext_pend.
  5. Make, any other case:
     - key_code<=rx_byte; key_ext<=ext_pend; key_down<=1; new_key<=1 for one cycle;
     - press_cnt<=press_cnt+1, modulo 2^CNT_W;
     - clear ext_pend.
     - A new make while another key is held replaces it: the last key pressed wins.
- new_key is registered and asserts the cycle after S_DECODE. It never asserts on a repeat, prefix or break.
- key_ascii is registered and updates in the same cycle as key_code.
- err_sticky<=1 on any cycle with kbd_overflow=1.
- kbd_ready dropping while in S_POP has no effect: the byte is still consumed.

Decomposition:
- Package ps2_pkg: BREAK_CODE=8'hF0, EXT_CODE=8'hE0, FSM state encoding (2-bit S_IDLE/S_POP/S_DECODE/S_WAIT).
- One sub-module, scancode_to_ascii: combinational ROM from set-2 scan code to lowercase ASCII.
  - Letters, digits, space 0x29->0x20, enter 0x5A->0x0D.
  - Default 0x00.

Test Plan:
- Feed 1C, F0, 1C with kbd_ready held while bytes remain -> one new_key pulse; key_code=0x1C, key_ascii=0x61; key_down 1 then 0; press_cnt=1.
- Continue with 1B, 1B, 1B, F0, 1B -> exactly one further new_key; press_cnt=2; key_ascii=0x73; key_down=0 at end; nextdata_n pulses exactly 8 times total, each pulse 1 cycle wide and pulses at least 4 cycles apart.
- E0, 75, then 75 without prefix -> key_ext=1 then key_ext=0 with two new_key pulses. Then F0, 75 -> key_down=0; key_ascii=0x00 throughout the E0 press.
- Press 1C, press 1B without releasing, then F0, 1C -> key_code=0x1B, key_down stays 1; F0, 1B -> key_down=0.
- 256 fresh presses alternating 1C/1B with CNT_W=8 -> press_cnt wraps to 0x00. Pulse kbd_overflow for 1 cycle -> err_sticky=1 until rst_n=0.
- Assert rst_n=0 during S_POP -> nextdata_n=1 and all outputs 0 asynchronously. After release, the same FIFO byte is popped again.
